// File: rtl/ssd_pkg.sv
// ssd_pkg
//   Shared definitions for the seven-segment scan front end.
//   Segment patterns are active-low: bits [7:1] = segments a..g, bit [0] = dp.
//   Provides the segment pattern type, blank/dash constants, the 0-9 digit
//   table and a helper that builds a blanked pattern that keeps its dp bit.
package ssd_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DASH  = 8'hFD;

  // a..g for digits 0..9; element [n] is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // All segments dark, decimal point still honoured.
  function automatic seg_t seg_blank_dp(input logic dp_on);
    seg_t s;
    s    = SEG_BLANK;
    s[0] = ~dp_on;
    return s;
  endfunction

endpackage

// File: rtl/ssd_scan_bcd_to_seg.sv
// bcd_to_seg
//   Combinational encoder from one BCD nibble plus its decimal-point enable
//   to an active-low segment pattern. Nibbles A-F show a dash.
// Ports:
//   digit  in  4  BCD nibble
//   dp_on  in  1  decimal point lit when 1
//   seg    out 8  pattern, [7:1] = a..g, [0] = dp, active-low
module bcd_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp_on,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (digit <= 4'd9) begin
      seg[7:1] = SEG_DIGITS[digit];
    end
    seg[0] = ~dp_on;
  end

endmodule

// File: rtl/ssd_scan.sv
// ssd_scan
//   Scan-and-encode front end for a four-digit seven-segment display.
//   A load strobe stages a 4-digit BCD value plus decimal points; the staged
//   value is committed to the segment outputs only at a frame boundary (the
//   edge where the digit select wraps 3->0), so a frame never shows a
//   half-updated value. A load on the boundary cycle itself is committed
//   directly on that edge.
//   Optional build macro SSD_SCAN_LZB_EN enables leading-zero blanking of
//   digits 3..1 at commit time.
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   synchronous active-low reset
//   load        in  1   capture strobe for value/dp
//   value       in  16  four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp          in  4   decimal-point enables, dp[n] for digit n
//   ssd_ctl     out 2   digit select 0..3
//   display0..3 out 8   active-low segment patterns
//   frame_tick  out 1   pulse on the edge ssd_ctl wraps 3->0
//   updated     out 1   pulse on the edge a value is committed
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [1:0]  ssd_ctl,
  output logic [7:0]  display0,
  output logic [7:0]  display1,
  output logic [7:0]  display2,
  output logic [7:0]  display3,
  output logic        frame_tick,
  output logic        updated
);

  localparam int             PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      scan_q, scan_d;
  logic [15:0]     pend_value_q, pend_value_d;
  logic [3:0]      pend_dp_q, pend_dp_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0][7:0] disp_q, disp_d;
  logic            frame_tick_q, frame_tick_d;
  logic            updated_q, updated_d;

  logic            presc_tc;
  logic            boundary;
  logic            commit;
  logic [15:0]     commit_value;
  logic [3:0]      commit_dp;
  logic [3:0]      blank;
  seg_t            enc_seg [4];
  logic [3:0][7:0] commit_seg;

  assign presc_tc = (presc_q == PRESC_LAST);
  assign boundary = presc_tc && (scan_q == 2'd3);

  // A load on the boundary cycle bypasses staging.
  assign commit_value = load ? value : pend_value_q;
  assign commit_dp    = load ? dp    : pend_dp_q;
  assign commit       = boundary && (load || pend_valid_q);

  for (genvar g = 0; g < 4; g++) begin : g_enc
    bcd_to_seg u_bcd_to_seg (
      .digit (commit_value[4*g +: 4]),
      .dp_on (commit_dp[g]),
      .seg   (enc_seg[g])
    );
  end

`ifdef SSD_SCAN_LZB_EN
  // A digit is dark only if it and every digit to its left are zero.
  always_comb begin
    blank    = '0;
    blank[3] = (commit_value[15:12] == 4'd0);
    blank[2] = blank[3] && (commit_value[11:8] == 4'd0);
    blank[1] = blank[2] && (commit_value[7:4] == 4'd0);
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      commit_seg[i] = blank[i] ? seg_blank_dp(commit_dp[i]) : enc_seg[i];
    end
  end

  always_comb begin
    presc_d      = presc_tc ? '0 : presc_q + PW'(1);
    scan_d       = presc_tc ? scan_q + 2'd1 : scan_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    frame_tick_d = boundary;
    updated_d    = commit;

    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
    // Any boundary drains the staging register, including the bypass case.
    if (boundary) begin
      pend_valid_d = 1'b0;
    end
    if (commit) begin
      disp_d = commit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      scan_q       <= 2'd0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= {4{SEG_BLANK}};
      frame_tick_q <= 1'b0;
      updated_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      scan_q       <= scan_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      frame_tick_q <= frame_tick_d;
      updated_q    <= updated_d;
    end
  end

  assign ssd_ctl    = scan_q;
  assign display0   = disp_q[0];
  assign display1   = disp_q[1];
  assign display2   = disp_q[2];
  assign display3   = disp_q[3];
  assign frame_tick = frame_tick_q;
  assign updated    = updated_q;

endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan
//   Directed plus randomized bench for ssd_scan with REFRESH_DIV = 4.
//   The reference model works from the cycle count since reset: select and
//   frame ticks follow from arithmetic on that count, and displays are
//   rewritten from a staged value whenever the count hits a frame boundary.
module tb_ssd_scan;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [1:0]  ssd_ctl;
  logic [7:0]  display0, display1, display2, display3;
  logic        frame_tick;
  logic        updated;

  int tests = 0;
  int fails = 0;

  // reference model state
  int         k;
  logic [7:0] m_disp [4];
  logic [15:0] m_pv;
  logic [3:0]  m_pd;
  bit          m_pvalid;
  bit          m_ft;
  bit          m_upd;

  logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100};

  ssd_scan #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .ssd_ctl    (ssd_ctl),
    .display0   (display0),
    .display1   (display1),
    .display2   (display2),
    .display3   (display3),
    .frame_tick (frame_tick),
    .updated    (updated)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] enc_digit(input logic [15:0] v, input logic [3:0] d, input int n);
    logic [3:0] nib;
    bit         dark;
    nib  = v[4*n +: 4];
    dark = 1'b0;
`ifdef SSD_SCAN_LZB_EN
    dark = (n > 0) && ((v >> (4 * n)) == 16'd0);
`endif
    if (dark) return {7'h7F, ~d[n]};
    if (nib > 4'd9) return {7'b1111110, ~d[n]};
    return {segtab[nib], ~d[n]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [15:0] v, input logic [3:0] d);
    bit bnd;
    rst_n = r;
    load  = l;
    value = v;
    dp    = d;
    @(posedge clk);
    if (!r) begin
      k        = 0;
      m_pvalid = 1'b0;
      m_ft     = 1'b0;
      m_upd    = 1'b0;
      for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
    end else begin
      k++;
      bnd   = (k % FRAME == 0);
      m_ft  = bnd;
      m_upd = 1'b0;
      if (bnd) begin
        if (l) begin
          for (int i = 0; i < 4; i++) m_disp[i] = enc_digit(v, d, i);
          m_upd = 1'b1;
        end else if (m_pvalid) begin
          for (int i = 0; i < 4; i++) m_disp[i] = enc_digit(m_pv, m_pd, i);
          m_upd = 1'b1;
        end
        m_pvalid = 1'b0;
      end else if (l) begin
        m_pv     = v;
        m_pd     = d;
        m_pvalid = 1'b1;
      end
    end
    #1;
    chk("ssd_ctl", {6'd0, ssd_ctl}, 8'((k / RD) % 4));
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, m_ft});
    chk("updated", {7'd0, updated}, {7'd0, m_upd});
    chk("display0", display0, m_disp[0]);
    chk("display1", display1, m_disp[1]);
    chk("display2", display2, m_disp[2]);
    chk("display3", display3, m_disp[3]);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 4'h0);
  endtask

  // Advance until the model count satisfies k % FRAME == m.
  task automatic idle_until(input int m);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != m; i++) step(1'b1, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic load_and_commit(input logic [15:0] v, input logic [3:0] d);
    idle_until(5);
    step(1'b1, 1'b1, v, d);
    idle_until(0);
  endtask

  initial begin
    logic [7:0] hi_zero;
`ifdef SSD_SCAN_LZB_EN
    hi_zero = 8'hFF;
`else
    hi_zero = 8'h03;
`endif
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    dp    = '0;
    k     = 0;
    m_pv  = '0;
    m_pd  = '0;
    for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;

    // reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 4'h0);
    chk("rst_ssd_ctl", {6'd0, ssd_ctl}, 8'h00);
    chk("rst_display0", display0, 8'hFF);
    chk("rst_display3", display3, 8'hFF);

    // scan cadence with nothing loaded
    idle(2 * FRAME + 3);
    chk("idle_updated", {7'd0, updated}, 8'h00);

    // mid-frame load, visible only at the boundary
    idle_until(6);
    step(1'b1, 1'b1, 16'h1208, 4'h0);
    idle(3);
    chk("held_display0", display0, 8'hFF);
    idle_until(0);
    chk("c1208_d0", display0, 8'h01);
    chk("c1208_d1", display1, 8'h03);
    chk("c1208_d2", display2, 8'h25);
    chk("c1208_d3", display3, 8'h9F);
    chk("c1208_upd", {7'd0, updated}, 8'h01);
    idle(1);
    chk("c1208_upd_drop", {7'd0, updated}, 8'h00);

    // last load wins
    idle_until(3);
    step(1'b1, 1'b1, 16'h1111, 4'h0);
    step(1'b1, 1'b1, 16'h2222, 4'h0);
    idle_until(0);
    chk("stage_d0", display0, 8'h25);
    chk("stage_d3", display3, 8'h25);

    // load on the boundary cycle commits on that same edge
    idle_until(FRAME - 1);
    step(1'b1, 1'b1, 16'h3333, 4'h0);
    chk("bypass_d0", display0, 8'h0D);
    chk("bypass_upd", {7'd0, updated}, 8'h01);
    idle(1);
    idle_until(0);
    chk("bypass_no_repeat", {7'd0, updated}, 8'h00);

    // encoding edges
    load_and_commit(16'hCCCC, 4'h0);
    chk("dash_d0", display0, 8'hFD);
    chk("dash_d3", display3, 8'hFD);
    load_and_commit(16'h0008, 4'b0001);
    chk("dp_d0", display0, 8'h00);
    chk("dp_d3", display3, hi_zero);

    // leading zeros
    load_and_commit(16'h0045, 4'h0);
    chk("lz45_d3", display3, hi_zero);
    chk("lz45_d2", display2, hi_zero);
    chk("lz45_d1", display1, 8'h99);
    chk("lz45_d0", display0, 8'h49);
    load_and_commit(16'h0000, 4'h0);
    chk("lz0_d0", display0, 8'h03);
    chk("lz0_d1", display1, hi_zero);

    // reset between load and boundary discards the staged value
    idle_until(5);
    step(1'b1, 1'b1, 16'h9999, 4'h0);
    idle(3);
    step(1'b0, 1'b0, 16'h0000, 4'h0);
    step(1'b0, 1'b0, 16'h0000, 4'h0);
    idle(3 * FRAME);
    chk("rst_discard_d0", display0, 8'hFF);
    chk("rst_discard_upd", {7'd0, updated}, 8'h00);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
